dct_transpose_ctrl: RTL and testbench
=====================================

Name: dct_transpose_ctrl

Overview:
Sequencer for the 8x8 transpose buffer between the row-DCT stage and the column-DCT stage of the JPEG accelerator.
- Accepts one 8x12-bit row per handshake from the row stage and issues the buffer write strobe and row index.
- Once a block is complete, issues column read strobes under back-pressure from the column stage.
- Flags valid and last for each column, and pulses block-done.

Parameters:
N_LINES, 8, rows per block and columns per block
IDX_W, 3, width of row/column indices; must equal clog2(N_LINES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous abort of the current block
in_valid  in  1  row stage presents a row on the buffer data_in
in_ready  out  1  controller accepts a row this cycle
t_wr  out  1  buffer write strobe
t_wr_row  out  IDX_W  row index written on t_wr
t_wr_bank  out  1  bank written (0 without DOUBLE_BUF_EN)
t_rd  out  1  buffer read strobe; buffer data_out is registered, so valid the next cycle
t_rd_col  out  IDX_W  column index read on t_rd
t_rd_bank  out  1  bank read (0 without DOUBLE_BUF_EN)
out_valid  out  1  buffer data_out holds a valid column
out_ready  in  1  column stage consumes data_out
out_last  out  1  qualifies out_valid for column N_LINES-1
block_done  out  1  one-cycle pulse on the handshake of the last column
busy  out  1  any row written or column pending in the current block

Behaviour:
- Reset (rst=1): state FILL; wr_row=0, rd_col=0; all strobes 0; out_valid=0, out_last=0, block_done=0; bank pointers 0.
- The clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- flush has identical effect to rst, and rst has priority over flush. A flush mid-block discards written rows and any pending column.
- Strobes are combinational from state and handshakes. Index outputs are registered counters.
- FILL state:
  - in_ready=1.
  - t_wr = in_valid & in_ready.
  - Each t_wr increments wr_row.
  - On t_wr with wr_row==N_LINES-1: wr_row wraps to 0 and state goes to DRAIN. This is the same cycle as the eighth write.
- DRAIN state:
  - in_ready=0.
  - t_rd = !out_valid | out_ready. This keeps one column in flight, and data_out is never overwritten before it is consumed.
  - Each t_rd increments rd_col.
  - On t_rd with rd_col==N_LINES-1: rd_col wraps to 0 and state goes to FILL. The buffer output register already holds the last column, so the next block may be written immediately.
- out_valid register:
  - Set on t_rd.
  - Cleared on out_ready & !t_rd.
  - Held otherwise.
  - Set and clear in the same cycle leaves it 1.
- out_last is registered and set on the t_rd for column N_LINES-1. It clears when that column is handshaken.
- block_done = out_valid & out_ready & out_last.
- busy = (state==DRAIN) | out_valid | (wr_row!=0).
- Latency:
  - First column t_rd occurs the cycle after the eighth write.
  - out_valid follows that t_rd by 1 cycle.
  - Sustained throughput is 1 row per cycle in and 1 column per cycle out. Without DOUBLE_BUF_EN, input and output phases alternate.
- in_valid while in DRAIN is ignored; the row stage holds it.
- out_ready while !out_valid has no effect.

Optional Feature:
DCT_TRANSPOSE_DOUBLE_BUF_EN
- Defined: ping-pong operation over two buffer banks.
  - Add full[1:0] flags, a wr_bank pointer and a rd_bank pointer.
  - in_ready = !full[wr_bank].
  - A completed fill sets full[wr_bank] and toggles wr_bank.
  - Reads proceed when full[rd_bank]=1.
  - The t_rd for the last column clears full[rd_bank] and toggles rd_bank.
  - Fill and drain run concurrently. When the fill-complete set and the drain-complete clear hit the same bank in the same cycle, the clear wins, because it belongs to the earlier block.
  - Requires the two-bank transpose variant, which takes bank-select inputs.
- Undefined: single-bank FILL/DRAIN alternation as described in Behaviour; t_wr_bank and t_rd_bank are tied to 0.

Decomposition:
- Package jpeg_ctrl_pkg contains:
  - constants N_LINES and IDX_W;
  - typedef enum logic {FILL, DRAIN} tctl_state_t;
  - typedef logic [IDX_W-1:0] line_idx_t.
- One natural sub-module is tctl_out_slot. It holds the out_valid/out_last register and the t_rd gating, and is reused by the column-stage controller.

Test Plan:
- Reset then 8 back-to-back rows with in_valid=1 -> t_wr_row 0..7, and t_rd col 0 on the cycle after the row-7 write. Then out_valid for 8 consecutive cycles with out_ready=1, out_last on col 7, and one block_done pulse.
- out_ready toggled 1,0,0,1 during drain -> t_rd is held while out_valid & !out_ready, no column is skipped or duplicated, and t_rd_col is monotonic 0..7.
- in_valid asserted through the whole DRAIN -> in_ready=0 and no t_wr. The next block's row 0 is written the cycle after the col-7 t_rd.
- flush after 5 rows written -> next cycle wr_row=0, busy=0, and the following 8 rows form a full block with correct indices.
- rst during DRAIN with out_valid=1 -> out_valid=0, state FILL, no block_done.
- With DCT_TRANSPOSE_DOUBLE_BUF_EN: 3 blocks streamed, out_ready=1 -> block 2 writes overlap block 1 reads, and in_ready drops only when both banks are full.

Source files
------------

// File: rtl/jpeg_ctrl_pkg.sv
// Shared constants and types for the JPEG accelerator control blocks.
package jpeg_ctrl_pkg;

  localparam int N_LINES = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } tctl_state_t;

  typedef logic [IDX_W-1:0] line_idx_t;

  localparam line_idx_t LAST_IDX = line_idx_t'(N_LINES - 1);

  // Row/column counter advance with wrap after the last line of a block.
  function automatic line_idx_t idx_next(input line_idx_t idx);
    line_idx_t nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + line_idx_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tctl_out_slot.sv
// One-deep output slot: gates buffer reads so the registered data_out is never
// overwritten before the downstream stage consumes it.
module tctl_out_slot (
  input  logic clk,
  input  logic rst,
  input  logic rd_en,
  input  logic rd_last,
  input  logic out_ready,
  output logic t_rd,
  output logic out_valid,
  output logic out_last
);

  logic out_valid_r;
  logic out_last_r;

  // Read strobe: slot empty, or the held column leaves this cycle.
  always_comb begin
    t_rd      = rd_en & (~out_valid_r | out_ready);
    out_valid = out_valid_r;
    out_last  = out_last_r;
  end

  // Slot occupancy and last-column flag; a new read wins over a consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (t_rd) begin
      out_valid_r <= 1'b1;
      out_last_r  <= rd_last;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
    end
  end

endmodule

// File: rtl/dct_transpose_ctrl.sv
// Transpose-buffer sequencer between the row-DCT and column-DCT stages.
// Define DCT_TRANSPOSE_DOUBLE_BUF_EN for ping-pong operation over two banks.
module dct_transpose_ctrl
  import jpeg_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             t_wr,
  output logic [IDX_W-1:0] t_wr_row,
  output logic             t_wr_bank,
  output logic             t_rd,
  output logic [IDX_W-1:0] t_rd_col,
  output logic             t_rd_bank,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             block_done,
  output logic             busy
);

  logic      clr_s;
  logic      rd_en_s;
  logic      wr_last_s;
  logic      rd_last_s;
  line_idx_t wr_row_r;
  line_idx_t rd_col_r;

`ifdef DCT_TRANSPOSE_DOUBLE_BUF_EN
  logic [1:0] full_r;
  logic [1:0] full_nxt_s;
  logic       wr_bank_r;
  logic       rd_bank_r;
`else
  tctl_state_t state_r;
`endif

  // Handshake strobes and status decoded from the current phase.
  always_comb begin
    clr_s     = rst | flush;
    wr_last_s = (wr_row_r == LAST_IDX);
    rd_last_s = (rd_col_r == LAST_IDX);
`ifdef DCT_TRANSPOSE_DOUBLE_BUF_EN
    in_ready  = ~full_r[wr_bank_r];
    rd_en_s   = full_r[rd_bank_r];
    t_wr_bank = wr_bank_r;
    t_rd_bank = rd_bank_r;
    busy      = (|full_r) | out_valid | (wr_row_r != '0);
`else
    in_ready  = (state_r == FILL);
    rd_en_s   = (state_r == DRAIN);
    t_wr_bank = 1'b0;
    t_rd_bank = 1'b0;
    busy      = (state_r == DRAIN) | out_valid | (wr_row_r != '0);
`endif
    t_wr       = in_valid & in_ready;
    t_wr_row   = wr_row_r;
    t_rd_col   = rd_col_r;
    block_done = out_valid & out_ready & out_last;
  end

  // Row and column index counters.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      wr_row_r <= '0;
      rd_col_r <= '0;
    end else begin
      if (t_wr) begin
        wr_row_r <= idx_next(wr_row_r);
      end else begin
        wr_row_r <= wr_row_r;
      end
      if (t_rd) begin
        rd_col_r <= idx_next(rd_col_r);
      end else begin
        rd_col_r <= rd_col_r;
      end
    end
  end

`ifdef DCT_TRANSPOSE_DOUBLE_BUF_EN
  // Bank full flags; the drain-complete clear is applied last so it wins.
  always_comb begin
    full_nxt_s = full_r;
    if (t_wr & wr_last_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (t_rd & rd_last_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
    end
  end

  // Bank pointers advance on completed fill / completed drain.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
    end else begin
      full_r    <= full_nxt_s;
      wr_bank_r <= (t_wr & wr_last_s) ? ~wr_bank_r : wr_bank_r;
      rd_bank_r <= (t_rd & rd_last_s) ? ~rd_bank_r : rd_bank_r;
    end
  end
`else
  // Single-bank FILL/DRAIN alternation.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      state_r <= FILL;
    end else begin
      case (state_r)
        FILL:    state_r <= (t_wr & wr_last_s) ? DRAIN : FILL;
        DRAIN:   state_r <= (t_rd & rd_last_s) ? FILL : DRAIN;
        default: state_r <= FILL;
      endcase
    end
  end
`endif

  tctl_out_slot u_out_slot (
    .clk       (clk),
    .rst       (clr_s),
    .rd_en     (rd_en_s),
    .rd_last   (rd_last_s),
    .out_ready (out_ready),
    .t_rd      (t_rd),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Self-checking bench for dct_transpose_ctrl against a block-level queue model.
module tb_dct_transpose_ctrl;
  import jpeg_ctrl_pkg::*;

`ifdef DCT_TRANSPOSE_DOUBLE_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             t_wr;
  logic [IDX_W-1:0] t_wr_row;
  logic             t_wr_bank;
  logic             t_rd;
  logic [IDX_W-1:0] t_rd_col;
  logic             t_rd_bank;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             block_done;
  logic             busy;

  dct_transpose_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .t_wr(t_wr), .t_wr_row(t_wr_row), .t_wr_bank(t_wr_bank),
    .t_rd(t_rd), .t_rd_col(t_rd_col), .t_rd_bank(t_rd_bank),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .block_done(block_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: completed blocks awaiting drain (by bank), rows written into the
  // block being filled, columns issued from the head block, one output slot.
  bit pend_q[$];
  int rows_in;
  int cols_out;
  bit wbank;
  bit rbank;
  bit slot_valid;
  bit slot_last;
  int done_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    pend_q.delete();
    rows_in = 0; cols_out = 0;
    wbank = 1'b0; rbank = 1'b0;
    slot_valid = 1'b0; slot_last = 1'b0;
  endtask

  task automatic cyc(input bit iv, input bit ordy, input bit fl, input bit rs);
    bit e_rdy, e_wr, e_rd, e_done;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
    #1;
    e_rdy  = (pend_q.size() < CAP);
    e_wr   = iv && e_rdy;
    e_rd   = (pend_q.size() > 0) && (!slot_valid || ordy);
    e_done = slot_valid && ordy && slot_last;
    check_val("in_ready",   in_ready,   e_rdy);
    check_val("t_wr",       t_wr,       e_wr);
    check_val("t_wr_row",   t_wr_row,   rows_in);
    check_val("t_wr_bank",  t_wr_bank,  wbank);
    check_val("t_rd",       t_rd,       e_rd);
    check_val("t_rd_col",   t_rd_col,   cols_out);
    check_val("t_rd_bank",  t_rd_bank,  rbank);
    check_val("out_valid",  out_valid,  slot_valid);
    check_val("out_last",   out_last,   slot_last);
    check_val("block_done", block_done, e_done);
    check_val("busy", busy, (pend_q.size() > 0) || slot_valid || (rows_in != 0));
    if (e_done) done_cnt++;
    if (fl || rs) begin
      model_reset();
    end else begin
      if (e_rd) begin
        slot_valid = 1'b1;
        slot_last  = (cols_out == N_LINES - 1);
        if (cols_out == N_LINES - 1) begin
          cols_out = 0;
          void'(pend_q.pop_front());
          if (CAP == 2) rbank = ~rbank;
        end else begin
          cols_out++;
        end
      end else if (ordy) begin
        slot_valid = 1'b0;
        slot_last  = 1'b0;
      end
      if (e_wr) begin
        if (rows_in == N_LINES - 1) begin
          rows_in = 0;
          pend_q.push_back(wbank);
          if (CAP == 2) wbank = ~wbank;
        end else begin
          rows_in++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    done_cnt = 0;
    repeat (2) @(posedge clk);

    // Back-to-back block with the column stage always ready.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("first_block_done_cnt", done_cnt, 1);

    // Back-pressure pattern 1,0,0,1 with in_valid held through the drain.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, ((i % 4) == 0) || ((i % 4) == 3), 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Flush after five rows, then a clean block.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("busy_after_flush", busy, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a stalled drain.
    done_cnt = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("no_done_after_rst", done_cnt, 0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 97) == 0, ($urandom % 151) == 0);

    // Saturated streaming for overlap of fill and drain.
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
